// File: rtl/mips64_ctrl_pkg.sv
// rtl/mips64_ctrl_pkg.sv - opcodes, state codes and select encodings shared by the multi-cycle control and the datapath muxes
package mips64_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LD    = 6'b110111;
  localparam logic [5:0] OP_SD    = 6'b111111;
  localparam logic [5:0] OP_DADDI = 6'b011000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_TRAP   = 3'd5;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } ctrl_t;

  // Opcodes that continue from DECODE into EXEC (J is handled in DECODE itself).
  function automatic logic is_exec_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LD) || (op == OP_SD) ||
           (op == OP_DADDI) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/ready_wait_timer.sv
// rtl/ready_wait_timer.sv - saturating wait counter that flags the last cycle allowed before a ready timeout
module ready_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  // High on the cycle whose not-ready would bring the count to MEM_TIMEOUT.
  assign limit_hit = (cnt >= LIMIT - CW'(1));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the 64-bit MIPS datapath; MULTICYCLE_PERF_EN adds cycle/instruction counters
module multicycle_ctrl
  import mips64_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       PCen,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic [2:0] state,
  output logic       trap
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [63:0] cyc_cnt,
  output logic [63:0] inst_cnt
`endif
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       trap_q;
  logic       waiting, ready_now, limit_hit;
  ctrl_t      c;

  assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ready_now = (state_q == S_FETCH) ? imem_ready : dmem_ready;

  ready_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!waiting || ready_now),
    .inc       (waiting && !ready_now),
    .limit_hit (limit_hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready)     state_d = S_DECODE;
        else if (limit_hit) state_d = S_TRAP;
      end
      S_DECODE: begin
        if (opcode == OP_J)          state_d = S_FETCH;
        else if (is_exec_op(opcode)) state_d = S_EXEC;
        else                         state_d = S_TRAP;
      end
      S_EXEC: begin
        case (op_q)
          OP_RTYPE, OP_DADDI: state_d = S_WB;
          OP_LD, OP_SD:       state_d = S_MEM;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ready)     state_d = (op_q == OP_LD) ? S_WB : S_FETCH;
        else if (limit_hit) state_d = S_TRAP;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d == S_TRAP)   trap_q <= 1'b1;
    end
  end

  // Strobes are forced low while reset is held so an aborted access cannot issue.
  always_comb begin
    c = '0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          c.mem_read = 1'b1;
          if (imem_ready) begin
            c.ir_write = 1'b1;
            c.pc_en    = 1'b1;
            c.pc_src   = PC_SEQ;
          end
        end
        S_DECODE: begin
          if (opcode == OP_J) begin
            c.pc_en  = 1'b1;
            c.pc_src = PC_JUMP;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_RTYPE: c.alu_op = ALU_FUNCT;
            OP_BEQ: begin
              c.alu_op = ALU_SUB;
              c.pc_src = PC_BRANCH;
              c.pc_en  = zero;
            end
            default: begin
              c.alu_src = 1'b1;
              c.alu_op  = ALU_ADD;
            end
          endcase
        end
        S_MEM: begin
          if (op_q == OP_LD) c.mem_read  = 1'b1;
          else               c.mem_write = 1'b1;
        end
        S_WB: begin
          c.reg_write  = 1'b1;
          c.reg_dst    = (op_q == OP_RTYPE);
          c.mem_to_reg = (op_q == OP_LD);
        end
        default: ;
      endcase
    end
  end

  assign PCen     = c.pc_en;
  assign PCSrc    = c.pc_src;
  assign IRWrite  = c.ir_write;
  assign RegDst   = c.reg_dst;
  assign RegWrite = c.reg_write;
  assign ALUSrc   = c.alu_src;
  assign ALUOp    = c.alu_op;
  assign MemRead  = c.mem_read;
  assign MemWrite = c.mem_write;
  assign MemToReg = c.mem_to_reg;
  assign state    = state_q;
  assign trap     = trap_q;

`ifdef MULTICYCLE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 64'd1;
      if (state_q == S_FETCH && imem_ready) inst_cnt <= inst_cnt + 64'd1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule
